// File: rtl/key_cam_pkg.sv
// Shared definitions for the key_cam reverse-lookup table: default geometry, width helpers,
// the default-geometry entry record and reset constants.
package key_cam_pkg;

  localparam int unsigned NrEntryDef = 8;
  localparam int unsigned KeyLenDef  = 5;
  localparam int unsigned DataLenDef = 32;

  // Index width; kept at least 1 bit so a degenerate table still has a legal index port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Count width must hold the value n itself, not just n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned IdxLenDef = idx_width(NrEntryDef);
  localparam int unsigned CntLenDef = cnt_width(NrEntryDef);

  typedef struct packed {
    logic                  valid;
    logic [KeyLenDef-1:0]  key;
    logic [DataLenDef-1:0] data;
  } entry_t;

  localparam entry_t EntryRst = '0;
  localparam logic   RespValidRst = 1'b0;
  localparam logic   RespHitRst   = 1'b0;

endpackage

// File: rtl/key_cam_prio_enc.sv
// Priority encoder for the key_cam match vector: reports whether any bit is set and the
// index of the lowest set bit (0 when none).
module key_cam_prio_enc #(
  parameter int unsigned NR_ENTRY = 8,
  parameter int unsigned IDX_LEN  = 3
) (
  input  logic [NR_ENTRY-1:0] match,
  output logic                hit,
  output logic [IDX_LEN-1:0]  idx
);

  // Scan downward so the last assignment made is the lowest matching index.
  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = NR_ENTRY - 1; i >= 0; i--) begin
      if (match[i]) begin
        idx = IDX_LEN'(i);
      end
    end
  end

endmodule

// File: rtl/key_cam.sv
// Reverse-lookup CAM: stores {key,data} pairs and answers "which key maps to this data" with a
// registered, handshaked search. Optional resp_multi output enabled by KEY_CAM_MULTI_HIT_EN.
module key_cam
  import key_cam_pkg::*;
#(
  parameter  int unsigned NR_ENTRY = NrEntryDef,
  parameter  int unsigned KEY_LEN  = KeyLenDef,
  parameter  int unsigned DATA_LEN = DataLenDef,
  localparam int unsigned IDX_LEN  = idx_width(NR_ENTRY),
  localparam int unsigned CNT_LEN  = cnt_width(NR_ENTRY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr_en,
  input  logic [IDX_LEN-1:0]  clr_idx,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_hit,
  output logic [KEY_LEN-1:0]  resp_key,
  output logic [IDX_LEN-1:0]  resp_idx,
  output logic [CNT_LEN-1:0]  count,
  output logic                full
`ifdef KEY_CAM_MULTI_HIT_EN
  ,
  output logic                resp_multi
`endif
);

  typedef struct packed {
    logic                valid;
    logic [KEY_LEN-1:0]  key;
    logic [DATA_LEN-1:0] data;
  } slot_t;

  slot_t [NR_ENTRY-1:0] entry_q, entry_d;
  logic  [CNT_LEN-1:0]  count_q, count_d;

  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [KEY_LEN-1:0]  resp_key_q, resp_key_d;
  logic [IDX_LEN-1:0]  resp_idx_q, resp_idx_d;

  logic [NR_ENTRY-1:0] match;
  logic                enc_hit;
  logic [IDX_LEN-1:0]  enc_idx;
  logic                accept;
  logic                wr_ok, clr_ok;

  // Table update: clear first so a write to the same index wins.
  always_comb begin
    wr_ok   = wr_en && (32'(wr_idx) < NR_ENTRY);
    clr_ok  = clr_en && (32'(clr_idx) < NR_ENTRY);
    entry_d = entry_q;
    if (clr_ok) begin
      entry_d[clr_idx].valid = 1'b0;
    end
    if (wr_ok) begin
      entry_d[wr_idx].valid = 1'b1;
      entry_d[wr_idx].key   = wr_key;
      entry_d[wr_idx].data  = wr_data;
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NR_ENTRY; i++) begin
      count_d = count_d + CNT_LEN'(entry_d[i].valid);
    end
  end

  // Search sees the table as registered, i.e. before this cycle's write/clear.
  always_comb begin
    for (int i = 0; i < NR_ENTRY; i++) begin
      match[i] = entry_q[i].valid && (entry_q[i].data == req_data);
    end
  end

  key_cam_prio_enc #(
    .NR_ENTRY (NR_ENTRY),
    .IDX_LEN  (IDX_LEN)
  ) u_prio_enc (
    .match (match),
    .hit   (enc_hit),
    .idx   (enc_idx)
  );

  assign req_ready = !resp_valid_q || resp_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_key_d   = resp_key_q;
    resp_idx_d   = resp_idx_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_hit_d   = enc_hit;
      resp_key_d   = enc_hit ? entry_q[enc_idx].key : '0;
      resp_idx_d   = enc_hit ? enc_idx : '0;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q      <= '0;
      count_q      <= '0;
      resp_valid_q <= RespValidRst;
      resp_hit_q   <= RespHitRst;
      resp_key_q   <= '0;
      resp_idx_q   <= '0;
    end else begin
      entry_q      <= entry_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_key_q   <= resp_key_d;
      resp_idx_q   <= resp_idx_d;
    end
  end

`ifdef KEY_CAM_MULTI_HIT_EN
  logic multi_d, multi_q, seen;

  // Second match found while scanning means two or more valid entries hit.
  always_comb begin
    seen    = 1'b0;
    multi_d = multi_q;
    if (accept) begin
      multi_d = 1'b0;
      for (int i = 0; i < NR_ENTRY; i++) begin
        if (match[i]) begin
          if (seen) begin
            multi_d = 1'b1;
          end
          seen = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      multi_q <= 1'b0;
    end else begin
      multi_q <= multi_d;
    end
  end

  assign resp_multi = multi_q;
`endif

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_key   = resp_key_q;
  assign resp_idx   = resp_idx_q;
  assign count      = count_q;
  assign full       = (count_q == CNT_LEN'(NR_ENTRY));

endmodule

// File: tb/tb_key_cam.sv
// Self-checking bench for key_cam: a reference table model feeds a scoreboard of expected
// responses, plus per-scenario inline checks of count/full/handshake state.
module tb_key_cam;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [4:0]  wr_key;
  logic [31:0] wr_data;
  logic        clr_en;
  logic [2:0]  clr_idx;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  logic [4:0]  resp_key;
  logic [2:0]  resp_idx;
  logic [3:0]  count;
  logic        full;
`ifdef KEY_CAM_MULTI_HIT_EN
  logic        resp_multi;
`endif

  key_cam u_dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_key     (wr_key),
    .wr_data    (wr_data),
    .clr_en     (clr_en),
    .clr_idx    (clr_idx),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hit   (resp_hit),
    .resp_key   (resp_key),
    .resp_idx   (resp_idx),
    .count      (count),
    .full       (full)
`ifdef KEY_CAM_MULTI_HIT_EN
    ,
    .resp_multi (resp_multi)
`endif
  );

  typedef struct {
    logic       hit;
    logic [4:0] key;
    logic [2:0] idx;
    logic       multi;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_valid[8];
  logic [4:0]  m_key[8];
  logic [31:0] m_data[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model_search(input logic [31:0] d);
    exp_t e;
    int   n;
    n       = 0;
    e.hit   = 1'b0;
    e.key   = '0;
    e.idx   = '0;
    e.multi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && m_data[i] == d) begin
        if (n == 0) begin
          e.hit = 1'b1;
          e.key = m_key[i];
          e.idx = 3'(i);
        end
        n++;
      end
    end
    e.multi = (n >= 2);
    return e;
  endfunction

  // Scoreboard monitor: samples mid-cycle, pops on handshake, pushes on accept, then
  // updates the reference table (so searches see pre-write state).
  initial begin
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      end else begin
        if (resp_valid && resp_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: got response hit=%0b key=%0h with none expected",
                     resp_hit, resp_key);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (resp_hit !== e.hit || resp_key !== e.key || resp_idx !== e.idx) begin
              errors++;
              $display("FAIL resp_fields: got hit=%0b key=%0h idx=%0d, want hit=%0b key=%0h idx=%0d",
                       resp_hit, resp_key, resp_idx, e.hit, e.key, e.idx);
            end
`ifdef KEY_CAM_MULTI_HIT_EN
            checks++;
            if (resp_multi !== e.multi) begin
              errors++;
              $display("FAIL resp_multi: got %0b want %0b", resp_multi, e.multi);
            end
`endif
          end
        end
        if (req_valid && req_ready) sb.push_back(model_search(req_data));
        if (clr_en) m_valid[clr_idx] = 1'b0;
        if (wr_en) begin
          m_valid[wr_idx] = 1'b1;
          m_key[wr_idx]   = wr_key;
          m_data[wr_idx]  = wr_data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (count !== 4'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_count: got count=%0d full=%0b want 0/0", count, full);
    end
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: got resp_valid=%0b req_ready=%0b want 0/1",
               resp_valid, req_ready);
    end
    req_valid = 1'b1;
    req_data  = 32'h0;
    tick();
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_search: got valid=%0b hit=%0b want 1/0", resp_valid, resp_hit);
    end
    tick();
  endtask

  task automatic test_write_search();
    wr_en   = 1'b1;
    wr_idx  = 3'd2;
    wr_key  = 5'h07;
    wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en     = 1'b0;
    req_valid = 1'b1;
    req_data  = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0;
    checks++;
    if (count !== 4'd1) begin
      errors++;
      $display("FAIL write_count: got %0d want 1", count);
    end
    tick();
  endtask

  task automatic test_multi();
    wr_en   = 1'b1;
    wr_idx  = 3'd1;
    wr_key  = 5'd3;
    wr_data = 32'h1234;
    tick();
    wr_idx = 3'd6;
    wr_key = 5'd9;
    tick();
    wr_en     = 1'b0;
    req_valid = 1'b1;
    req_data  = 32'h1234;
    tick();
    req_valid = 1'b0;
    checks++;
    if (resp_key !== 5'd3 || resp_idx !== 3'd1) begin
      errors++;
      $display("FAIL multi_prio: got key=%0d idx=%0d want 3/1", resp_key, resp_idx);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    wr_en     = 1'b1;
    wr_idx    = 3'd0;
    wr_key    = 5'h11;
    wr_data   = 32'hCAFE;
    req_valid = 1'b1;
    req_data  = 32'hCAFE;
    tick();
    wr_en = 1'b0;
    checks++;
    if (resp_hit !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_miss: got hit=%0b want 0", resp_hit);
    end
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_data   = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0;
    clr_en    = 1'b1;
    clr_idx   = 3'd2;
    checks++;
    if (req_ready !== 1'b0 || resp_hit !== 1'b1 || resp_key !== 5'h07) begin
      errors++;
      $display("FAIL hold_first: got ready=%0b hit=%0b key=%0h want 0/1/07",
               req_ready, resp_hit, resp_key);
    end
    tick();
    clr_en = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_key !== 5'h07 || resp_idx !== 3'd2 || req_ready !== 1'b0)
    begin
      errors++;
      $display("FAIL hold_after_clear: got valid=%0b key=%0h idx=%0d ready=%0b want 1/07/2/0",
               resp_valid, resp_key, resp_idx, req_ready);
    end
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL hold_count: got %0d want 3", count);
    end
    resp_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat[3];
    pat[0] = 32'h1234;
    pat[1] = 32'hCAFE;
    pat[2] = 32'h999;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_data = pat[i];
      tick();
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stream %0d: got valid=%0b ready=%0b want 1/1", i, resp_valid,
                 req_ready);
      end
    end
    req_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_full_and_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_idx  = 3'(i);
      wr_key  = 5'(i + 16);
      wr_data = 32'h100 + 32'(i);
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (count !== 4'd8 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_count: got count=%0d full=%0b want 8/1", count, full);
    end
    wr_en   = 1'b1;
    clr_en  = 1'b1;
    wr_idx  = 3'd4;
    clr_idx = 3'd4;
    wr_key  = 5'h1f;
    wr_data = 32'h500;
    tick();
    wr_en = 1'b0;
    checks++;
    if (count !== 4'd8) begin
      errors++;
      $display("FAIL wr_clr_same: got count=%0d want 8", count);
    end
    clr_idx = 3'd3;
    tick();
    checks++;
    if (count !== 4'd7 || full !== 1'b0) begin
      errors++;
      $display("FAIL clear_count: got count=%0d full=%0b want 7/0", count, full);
    end
    tick();
    clr_en = 1'b0;
    checks++;
    if (count !== 4'd7) begin
      errors++;
      $display("FAIL clear_invalid: got count=%0d want 7", count);
    end
    req_valid = 1'b1;
    req_data  = 32'h500;
    tick();
    req_data = 32'h103;
    tick();
    req_valid = 1'b0;
    tick();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_data   = 32'h105;
    tick();
    req_valid = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (count !== 4'd0 || full !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got count=%0d full=%0b valid=%0b want 0/0/0", count, full,
               resp_valid);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_key     = '0;
    wr_data    = '0;
    clr_en     = 1'b0;
    clr_idx    = '0;
    req_valid  = 1'b0;
    req_data   = '0;
    resp_ready = 1'b1;
    test_reset();
    test_write_search();
    test_multi();
    test_same_cycle();
    test_hold();
    test_back_to_back();
    test_full_and_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d responses outstanding want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
